// File: rtl/npu_cfg_pkg.sv
// rtl/npu_cfg_pkg.sv - shared NPU array geometry, sequencer state encoding and width helpers
package npu_cfg_pkg;

    localparam int DEF_VEC = 10;
    localparam int DEF_PE  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Never return a zero width, so single-entry dimensions still get a 1-bit field.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// rtl/mac_sequencer_if.sv - buffer read / MAC drive / result tag bundle of the MAC sequencer
interface mac_sequencer_if #(
    parameter int DAW = 1,
    parameter int PAW = 1,
    parameter int PXW = 1,
    parameter int GW  = 1
);
    logic           rd_en;
    logic [DAW-1:0] data_rd_addr;
    logic [PAW-1:0] param_rd_addr;
    logic           mac_in_valid;
    logic           mac_acc_clr;
    logic           res_valid;
    logic [PXW-1:0] res_pixel;
    logic [GW-1:0]  res_group;

    modport master (
        output rd_en, data_rd_addr, param_rd_addr, mac_in_valid, mac_acc_clr,
               res_valid, res_pixel, res_group
    );

    modport slave (
        input rd_en, data_rd_addr, param_rd_addr, mac_in_valid, mac_acc_clr,
              res_valid, res_pixel, res_group
    );
endinterface

// File: rtl/mac_tag_pipe.sv
// rtl/mac_tag_pipe.sv - fixed-depth shift register with synchronous flush, all stages visible
module mac_tag_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taps <= '0;
        end else if (flush) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - pixel/group/step issue controller for the MAC array with result tagging
module mac_sequencer
    import npu_cfg_pkg::*;
#(
    parameter int IN_CH      = 40,
    parameter int VEC        = DEF_VEC,
    parameter int OUT_CH     = 80,
    parameter int PE         = DEF_PE,
    parameter int PIXELS     = 1024,
    parameter int PIPE_DELAY = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic stall,
    input  logic abort,
    output logic busy,
    output logic done,
    mac_sequencer_if.master mac
);

    localparam int STEPS  = IN_CH / VEC;
    localparam int GROUPS = OUT_CH / PE;
    localparam int DAW    = width_of(PIXELS * STEPS);
    localparam int PAW    = width_of(GROUPS * STEPS);
    localparam int PXW    = width_of(PIXELS);
    localparam int GW     = width_of(GROUPS);
    localparam int SW     = width_of(STEPS);
    localparam int TAGW   = 2 + PXW + GW;
    localparam int DEPTH  = PIPE_DELAY + 1;

    seq_state_t state, state_nx;
    logic       issue;
    logic       last_beat;
    logic       inflight;

    logic [SW-1:0]  step;
    logic [GW-1:0]  group;
    logic [PXW-1:0] pixel;
    logic [DAW-1:0] pix_base;
    logic [PAW-1:0] grp_base;

    logic           rd_en_q;
    logic           clr_q;
    logic [DAW-1:0] data_addr_q;
    logic [PAW-1:0] param_addr_q;
    logic           res_valid_q;
    logic [PXW-1:0] res_pixel_q;
    logic [GW-1:0]  res_group_q;

    logic [TAGW-1:0]             tag_in;
    logic [DEPTH-1:0][TAGW-1:0]  tag_taps;
    logic [TAGW-1:0]             tag_out;
    logic [0:0][1:0]             mac_taps;

    assign last_beat = (pixel == PXW'(PIXELS - 1)) && (group == GW'(GROUPS - 1))
                    && (step == SW'(STEPS - 1));

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (last_beat) state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: if (!inflight) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort) begin
            state_nx = ST_IDLE;
            issue    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Base registers track pixel*STEPS and group*STEPS so no multiplier is needed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step         <= '0;
            group        <= '0;
            pixel        <= '0;
            pix_base     <= '0;
            grp_base     <= '0;
            rd_en_q      <= 1'b0;
            clr_q        <= 1'b0;
            data_addr_q  <= '0;
            param_addr_q <= '0;
        end else begin
            rd_en_q <= issue;
            clr_q   <= issue && (step == '0);
            if (abort || state == ST_IDLE) begin
                step     <= '0;
                group    <= '0;
                pixel    <= '0;
                pix_base <= '0;
                grp_base <= '0;
            end else if (issue) begin
                data_addr_q  <= pix_base + DAW'(step);
                param_addr_q <= grp_base + PAW'(step);
                if (step == SW'(STEPS - 1)) begin
                    step <= '0;
                    if (group == GW'(GROUPS - 1)) begin
                        group    <= '0;
                        grp_base <= '0;
                        pixel    <= pixel + 1'b1;
                        pix_base <= pix_base + DAW'(STEPS);
                    end else begin
                        group    <= group + 1'b1;
                        grp_base <= grp_base + PAW'(STEPS);
                    end
                end else begin
                    step <= step + 1'b1;
                end
            end
        end
    end

    assign tag_in = {issue, step == SW'(STEPS - 1), pixel, group};

    mac_tag_pipe #(.WIDTH(TAGW), .DEPTH(DEPTH)) u_tag_pipe (
        .clk   (clk),
        .rstn  (rstn),
        .flush (abort),
        .din   (tag_in),
        .taps  (tag_taps)
    );

    mac_tag_pipe #(.WIDTH(2), .DEPTH(1)) u_mac_delay (
        .clk   (clk),
        .rstn  (rstn),
        .flush (abort),
        .din   ({rd_en_q, clr_q}),
        .taps  (mac_taps)
    );

    assign tag_out = tag_taps[DEPTH-1];

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight = inflight | tag_taps[i][TAGW-1];
        end
    end

    // The result register adds the final cycle so results land PIPE_DELAY after the last MAC beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid_q <= 1'b0;
            res_pixel_q <= '0;
            res_group_q <= '0;
        end else begin
            res_valid_q <= !abort && tag_out[TAGW-1] && tag_out[TAGW-2];
            if (!abort && tag_out[TAGW-1] && tag_out[TAGW-2]) begin
                res_pixel_q <= tag_out[GW +: PXW];
                res_group_q <= tag_out[GW-1:0];
            end
        end
    end

    assign busy              = (state == ST_RUN) || (state == ST_DRAIN);
    assign done              = (state == ST_DONE);
    assign mac.rd_en         = rd_en_q;
    assign mac.data_rd_addr  = data_addr_q;
    assign mac.param_rd_addr = param_addr_q;
    assign mac.mac_in_valid  = mac_taps[0][1];
    assign mac.mac_acc_clr   = mac_taps[0][0];
    assign mac.res_valid     = res_valid_q;
    assign mac.res_pixel     = res_pixel_q;
    assign mac.res_group     = res_group_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed self-checking bench for mac_sequencer (small and default geometry)
module tb_mac_sequencer;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic start_s = 1'b0, stall_s = 1'b0, abort_s = 1'b0, busy_s, done_s;
    logic start_d = 1'b0, stall_d = 1'b0, abort_d = 1'b0, busy_d, done_d;

    mac_sequencer_if #(.DAW(2),  .PAW(2), .PXW(1),  .GW(1)) bus_s ();
    mac_sequencer_if #(.DAW(12), .PAW(5), .PXW(10), .GW(3)) bus_d ();

    mac_sequencer #(.IN_CH(20), .VEC(10), .OUT_CH(32), .PE(16), .PIXELS(2), .PIPE_DELAY(3)) dut_s (
        .clk(clk), .rstn(rstn), .start(start_s), .stall(stall_s), .abort(abort_s),
        .busy(busy_s), .done(done_s), .mac(bus_s)
    );

    mac_sequencer dut_d (
        .clk(clk), .rstn(rstn), .start(start_d), .stall(stall_d), .abort(abort_d),
        .busy(busy_d), .done(done_d), .mac(bus_d)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected per-cycle trace; cycle c is the negedge after edge k+c, k = edge sampling start.
    localparam int NC = 40;
    logic e_rd[NC], e_mv[NC], e_clr[NC], e_rv[NC], e_busy[NC], e_done[NC];
    int   e_da[NC], e_pa[NC], e_rp[NC], e_rg[NC];
    logic d_start[NC], d_stall[NC], d_abort[NC];

    task automatic clear_exp();
        for (int c = 0; c < NC; c++) begin
            e_rd[c] = 0; e_mv[c] = 0; e_clr[c] = 0; e_rv[c] = 0; e_busy[c] = 0; e_done[c] = 0;
            e_da[c] = 0; e_pa[c] = 0; e_rp[c] = 0; e_rg[c] = 0;
            d_start[c] = 0; d_stall[c] = 0; d_abort[c] = 0;
        end
    endtask

    task automatic beat(input int c, input int da, input int pa, input logic clr);
        e_rd[c] = 1; e_da[c] = da; e_pa[c] = pa;
        e_mv[c+1] = 1; e_clr[c+1] = clr;
    endtask

    task automatic res(input int c, input int p, input int g);
        e_rv[c] = 1; e_rp[c] = p; e_rg[c] = g;
    endtask

    task automatic busy_to(input int last);
        for (int c = 0; c <= last; c++) e_busy[c] = 1;
    endtask

    // Unstalled 8-beat frame: beats on cycles 1..8, results 3 cycles after each step-1 MAC beat.
    task automatic basic_exp();
        beat(1, 0, 0, 1); beat(2, 1, 1, 0); beat(3, 0, 2, 1); beat(4, 1, 3, 0);
        beat(5, 2, 0, 1); beat(6, 3, 1, 0); beat(7, 2, 2, 1); beat(8, 3, 3, 0);
        res(6, 0, 0); res(8, 0, 1); res(10, 1, 0); res(12, 1, 1);
        busy_to(12);
        e_done[13] = 1;
    endtask

    task automatic run_window(input string name, input int n);
        @(negedge clk);
        start_s = 1'b1;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            chk($sformatf("%s rd_en@%0d", name, c), bus_s.rd_en, e_rd[c]);
            chk($sformatf("%s mac_in_valid@%0d", name, c), bus_s.mac_in_valid, e_mv[c]);
            chk($sformatf("%s mac_acc_clr@%0d", name, c), bus_s.mac_acc_clr, e_clr[c]);
            chk($sformatf("%s res_valid@%0d", name, c), bus_s.res_valid, e_rv[c]);
            chk($sformatf("%s busy@%0d", name, c), busy_s, e_busy[c]);
            chk($sformatf("%s done@%0d", name, c), done_s, e_done[c]);
            if (e_rd[c]) begin
                chk($sformatf("%s data_rd_addr@%0d", name, c), bus_s.data_rd_addr, e_da[c]);
                chk($sformatf("%s param_rd_addr@%0d", name, c), bus_s.param_rd_addr, e_pa[c]);
            end
            if (e_rv[c]) begin
                chk($sformatf("%s res_pixel@%0d", name, c), bus_s.res_pixel, e_rp[c]);
                chk($sformatf("%s res_group@%0d", name, c), bus_s.res_group, e_rg[c]);
            end
            start_s = d_start[c];
            stall_s = d_stall[c];
            abort_s = d_abort[c];
        end
        start_s = 1'b0; stall_s = 1'b0; abort_s = 1'b0;
    endtask

    task automatic chk_zero_all(input string name);
        chk({name, " rd_en"}, bus_s.rd_en, 0);
        chk({name, " data_rd_addr"}, bus_s.data_rd_addr, 0);
        chk({name, " param_rd_addr"}, bus_s.param_rd_addr, 0);
        chk({name, " mac_in_valid"}, bus_s.mac_in_valid, 0);
        chk({name, " mac_acc_clr"}, bus_s.mac_acc_clr, 0);
        chk({name, " res_valid"}, bus_s.res_valid, 0);
        chk({name, " res_pixel"}, bus_s.res_pixel, 0);
        chk({name, " res_group"}, bus_s.res_group, 0);
        chk({name, " busy"}, busy_s, 0);
        chk({name, " done"}, done_s, 0);
    endtask

    // Statistics on the default-geometry instance, compared in the initial block.
    int d_rd = 0, d_res = 0, d_done = 0, d_wraps = 0, d_seqerr = 0;
    int d_last_da = -1, d_last_rp = -1, d_last_rg = -1, d_prev_pa = -1;
    always @(negedge clk) begin
        if (bus_d.rd_en) begin
            d_rd++;
            d_last_da = int'(bus_d.data_rd_addr);
            if (d_prev_pa == 19 && bus_d.param_rd_addr == 5'd0) d_wraps++;
            else if (d_prev_pa >= 0 && int'(bus_d.param_rd_addr) != d_prev_pa + 1) d_seqerr++;
            d_prev_pa = int'(bus_d.param_rd_addr);
        end
        if (bus_d.res_valid) begin
            d_res++;
            d_last_rp = int'(bus_d.res_pixel);
            d_last_rg = int'(bus_d.res_group);
        end
        if (done_d) d_done++;
    end

    int cyc;

    initial begin
        #2 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero_all("reset");
        rstn = 1'b1;
        @(negedge clk);

        clear_exp(); basic_exp();
        run_window("basic", 16);

        clear_exp();
        beat(1, 0, 0, 1); beat(2, 1, 1, 0); beat(3, 0, 2, 1); beat(7, 1, 3, 0);
        beat(8, 2, 0, 1); beat(9, 3, 1, 0); beat(10, 2, 2, 1); beat(11, 3, 3, 0);
        res(6, 0, 0); res(11, 0, 1); res(13, 1, 0); res(15, 1, 1);
        busy_to(15); e_done[16] = 1;
        d_stall[3] = 1; d_stall[4] = 1; d_stall[5] = 1;
        run_window("stall", 19);

        clear_exp(); basic_exp();
        d_start[3] = 1; d_start[10] = 1;
        run_window("start_ignored", 18);

        clear_exp();
        beat(1, 0, 0, 1); beat(2, 1, 1, 0); beat(3, 0, 2, 1); beat(4, 1, 3, 0);
        beat(5, 2, 0, 1); beat(6, 3, 1, 0);
        e_mv[7] = 0; e_clr[7] = 0;
        res(6, 0, 0);
        busy_to(6);
        d_abort[6] = 1;
        run_window("abort", 14);

        clear_exp(); basic_exp();
        run_window("restart", 15);

        clear_exp(); basic_exp();
        run_window("pre_reset", 10);
        rstn = 1'b0;
        #1;
        chk_zero_all("async_reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset busy@%0d", i), busy_s, 0);
            chk($sformatf("post_reset rd_en@%0d", i), bus_s.rd_en, 0);
            chk($sformatf("post_reset res_valid@%0d", i), bus_s.res_valid, 0);
        end

        @(negedge clk);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        chk("dflt busy_after_start", busy_d, 1);
        cyc = 0;
        while (!done_d && cyc < 25000) begin
            @(negedge clk);
            cyc++;
        end
        chk("dflt done_cycle", cyc, 20492);
        chk("dflt busy_with_done", busy_d, 0);
        repeat (4) @(negedge clk);
        chk("dflt rd_en_beats", d_rd, 20480);
        chk("dflt res_valid_pulses", d_res, 5120);
        chk("dflt last_data_rd_addr", d_last_da, 4095);
        chk("dflt param_wraps", d_wraps, 1023);
        chk("dflt param_seq_errors", d_seqerr, 0);
        chk("dflt last_res_pixel", d_last_rp, 1023);
        chk("dflt last_res_group", d_last_rg, 4);
        chk("dflt done_pulses", d_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
